tile_config_loader: RTL and testbench

- Streams configuration words from the bitstream source into one logic tile's 524-bit configuration bus, then releases the tile from reset.
- Sits between the fabric-level bitstream fetcher and a single logic tile, which has 4 logic elements at 65 bits each and a 264-bit switchbox.
- Holds the tile in reset while loading. Updates the tile's configuration atomically from a shadow register.

---
 rtl/tile_config_loader_if.sv | 32 +++
 rtl/tile_config_loader.sv | 178 +++++++++++++++++
 tb/tb_tile_config_loader.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tile_config_loader_if.sv
// ---------------------------------------------------------------------------
// tile_config_loader_if
// Word-stream channel from the fabric bitstream fetcher to a tile loader.
//
// Signals:
//   word_valid  source -> loader  word_data holds a valid configuration word
//   word_data   source -> loader  configuration word, least significant first
//   word_ready  loader -> source  loader accepts a word this cycle
//
// Modports:
//   master  bitstream source side (drives valid/data, observes ready)
//   slave   loader side (observes valid/data, drives ready)
// ---------------------------------------------------------------------------
interface tile_config_loader_if #(
    parameter int WORD_WIDTH = 32
);
    logic                  word_valid;
    logic [WORD_WIDTH-1:0] word_data;
    logic                  word_ready;

    modport master (
        output word_valid,
        output word_data,
        input  word_ready
    );

    modport slave (
        input  word_valid,
        input  word_data,
        output word_ready
    );
endinterface

// File: rtl/tile_config_loader.sv
// ---------------------------------------------------------------------------
// tile_config_loader
// Streams NUM_WORDS configuration words into a shadow register, commits the
// shadow atomically onto the tile configuration bus, holds the tile in reset
// for one settle cycle and then releases it.
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   start        in   begin a frame load (honoured in IDLE or DONE only)
//   abort        in   abandon a load in progress (LOAD only)
//   word_if      slave word stream (word_valid / word_data / word_ready)
//   config_out   out  registered configuration bus to the tile
//   tile_nreset  out  active-low tile reset
//   busy         out  high in LOAD, COMMIT and SETTLE
//   done         out  high in DONE
//   word_count   out  words accepted in the current frame (saturating)
//
// All status outputs are registered: they are computed from the next state
// so that they line up with the state register on every edge.
// ---------------------------------------------------------------------------
module tile_config_loader #(
    parameter int CONFIG_WIDTH = 524,
    parameter int WORD_WIDTH   = 32,
    parameter int NUM_WORDS    = 17
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    abort,
    tile_config_loader_if.slave     word_if,
    output logic [CONFIG_WIDTH-1:0] config_out,
    output logic                    tile_nreset,
    output logic                    busy,
    output logic                    done,
    output logic [4:0]              word_count
);

    // Bits of the final word that land on the bus; the rest are discarded.
    localparam int        LAST_BITS = CONFIG_WIDTH - (NUM_WORDS - 1) * WORD_WIDTH;
    localparam logic [4:0] LAST_IDX = 5'(NUM_WORDS - 1);
    localparam logic [4:0] MAX_CNT  = 5'(NUM_WORDS);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_COMMIT = 3'd2;
    localparam logic [2:0] ST_SETTLE = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    logic [2:0]              r_state;
    logic [CONFIG_WIDTH-1:0] r_shadow;
    logic [CONFIG_WIDTH-1:0] r_config;
    logic [4:0]              r_word_count;
    logic                    r_loaded;
    logic                    r_tile_nreset;
    logic                    r_word_ready;
    logic                    r_busy;
    logic                    r_done;

    logic [2:0]              w_next_state;
    logic                    w_accept;
    logic                    w_start_frame;

    // Next-state decode; abort beats word acceptance in LOAD, start beats abort elsewhere.
    always_comb begin
        w_next_state  = r_state;
        w_accept      = 1'b0;
        w_start_frame = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_next_state  = ST_LOAD;
                    w_start_frame = 1'b1;
                end else begin
                    w_next_state  = r_state;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    w_next_state = ST_IDLE;
                end else if (word_if.word_valid) begin
                    w_accept = 1'b1;
                    if (r_word_count == LAST_IDX) begin
                        w_next_state = ST_COMMIT;
                    end else begin
                        w_next_state = ST_LOAD;
                    end
                end else begin
                    w_next_state = ST_LOAD;
                end
            end
            ST_COMMIT: begin
                w_next_state = ST_SETTLE;
            end
            ST_SETTLE: begin
                w_next_state = ST_DONE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State register and registered status outputs derived from the next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_word_ready  <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_tile_nreset <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_word_ready  <= (w_next_state == ST_LOAD);
            r_busy        <= (w_next_state == ST_LOAD) ||
                             (w_next_state == ST_COMMIT) ||
                             (w_next_state == ST_SETTLE);
            r_done        <= (w_next_state == ST_DONE);
            // In IDLE the tile runs only if a full frame was ever committed.
            if (w_next_state == ST_IDLE) begin
                r_tile_nreset <= r_loaded;
            end else begin
                r_tile_nreset <= (w_next_state == ST_DONE);
            end
        end
    end

    // Shadow register fill and saturating word counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_shadow     <= {CONFIG_WIDTH{1'b0}};
            r_word_count <= 5'd0;
        end else if (w_start_frame) begin
            r_shadow     <= {CONFIG_WIDTH{1'b0}};
            r_word_count <= 5'd0;
        end else if (w_accept) begin
            for (int i = 0; i < NUM_WORDS - 1; i++) begin
                if (r_word_count == 5'(i)) begin
                    r_shadow[i*WORD_WIDTH +: WORD_WIDTH] <= word_if.word_data;
                end
            end
            // Final word is partial: only its low LAST_BITS fit on the bus.
            if (r_word_count == LAST_IDX) begin
                r_shadow[CONFIG_WIDTH-1 -: LAST_BITS] <= word_if.word_data[LAST_BITS-1:0];
            end
            if (r_word_count < MAX_CNT) begin
                r_word_count <= r_word_count + 5'd1;
            end else begin
                r_word_count <= r_word_count;
            end
        end else begin
            r_shadow     <= r_shadow;
            r_word_count <= r_word_count;
        end
    end

    // Atomic commit of the shadow onto the tile configuration bus.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_config <= {CONFIG_WIDTH{1'b0}};
            r_loaded <= 1'b0;
        end else if (r_state == ST_COMMIT) begin
            r_config <= r_shadow;
            r_loaded <= 1'b1;
        end else begin
            r_config <= r_config;
            r_loaded <= r_loaded;
        end
    end

    assign word_if.word_ready = r_word_ready;
    assign config_out         = r_config;
    assign tile_nreset        = r_tile_nreset;
    assign busy               = r_busy;
    assign done               = r_done;
    assign word_count         = r_word_count;

endmodule

// File: tb/tb_tile_config_loader.sv
// ---------------------------------------------------------------------------
// tb_tile_config_loader
// Randomised frame loads against a frame-level reference model: the expected
// bus image is the concatenation of the frame words truncated to the bus
// width, and the expected handshake timing follows the load/commit/settle
// sequence of the loader.
// ---------------------------------------------------------------------------
module tb_tile_config_loader;
    localparam int CW = 524;
    localparam int WW = 32;
    localparam int NW = 17;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic [CW-1:0] config_out;
    logic          tile_nreset;
    logic          busy;
    logic          done;
    logic [4:0]    word_count;

    tile_config_loader_if #(.WORD_WIDTH(WW)) wif ();

    tile_config_loader #(
        .CONFIG_WIDTH(CW),
        .WORD_WIDTH  (WW),
        .NUM_WORDS   (NW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .word_if    (wif),
        .config_out (config_out),
        .tile_nreset(tile_nreset),
        .busy       (busy),
        .done       (done),
        .word_count (word_count)
    );

    always #5 clock = ~clock;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [CW-1:0] exp_cfg;
    logic          exp_loaded;
    logic          exp_done;
    int            exp_cnt;
    logic [WW-1:0] frame [NW];

    task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Reference image: words laid end to end, least significant first, cut to the bus width.
    function automatic logic [CW-1:0] pack_frame();
        logic [NW*WW-1:0] t;
        for (int i = 0; i < NW; i++) t[i*WW +: WW] = frame[i];
        return t[CW-1:0];
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_status(input string tag, input logic eb, input logic ed,
                                input logic en, input logic er);
        check({tag, "_busy"},  CW'(busy),           CW'(eb));
        check({tag, "_done"},  CW'(done),           CW'(ed));
        check({tag, "_nrst"},  CW'(tile_nreset),    CW'(en));
        check({tag, "_ready"}, CW'(wif.word_ready), CW'(er));
    endtask

    // stop_mode: 0 = full frame, 1 = abort after stop_at words, 2 = reset after stop_at words
    task automatic run_frame(input int stop_mode, input int stop_at, input int gap_pct, input bit poke_start);
        int            acc;
        int            cyc;
        logic          v;
        logic [CW-1:0] new_cfg;
        acc = 0;
        cyc = 0;
        start = 1'b1;
        abort = ($urandom_range(0, 1) == 1);   // start must win over abort here
        tick();
        start = 1'b0;
        abort = 1'b0;
        check_status("start", 1'b1, 1'b0, 1'b0, 1'b1);
        check("start_cnt", CW'(word_count), CW'(0));
        check("start_cfg", config_out, exp_cfg);
        while (acc < NW && cyc < 200) begin
            if (stop_mode != 0 && acc == stop_at) break;
            cyc++;
            v = ($urandom_range(0, 99) >= gap_pct);
            wif.word_valid = v;
            wif.word_data  = v ? frame[acc] : WW'($urandom);
            start = poke_start && ($urandom_range(0, 3) == 0);
            tick();
            start = 1'b0;
            if (v) acc++;
            check("load_cnt", CW'(word_count), CW'(acc));
            check("load_cfg", config_out, exp_cfg);
            if (acc < NW) check_status("load", 1'b1, 1'b0, 1'b0, 1'b1);
        end
        wif.word_valid = 1'b0;
        if (stop_mode == 0) begin
            check("load_words", CW'(acc), CW'(NW));
            // COMMIT cycle: abort and stray valid beats must be ignored
            abort          = ($urandom_range(0, 1) == 1);
            wif.word_valid = 1'b1;
            wif.word_data  = WW'($urandom);
            check_status("commit", 1'b1, 1'b0, 1'b0, 1'b0);
            check("commit_cfg_old", config_out, exp_cfg);
            new_cfg = pack_frame();
            tick();
            abort = ($urandom_range(0, 1) == 1);
            check("settle_cfg", config_out, new_cfg);
            check_status("settle", 1'b1, 1'b0, 1'b0, 1'b0);
            tick();
            abort          = 1'b0;
            wif.word_valid = 1'b0;
            check_status("done", 1'b0, 1'b1, 1'b1, 1'b0);
            check("done_cfg", config_out, new_cfg);
            check("done_cnt", CW'(word_count), CW'(NW));
            exp_cfg    = new_cfg;
            exp_loaded = 1'b1;
            exp_done   = 1'b1;
            exp_cnt    = NW;
        end else if (stop_mode == 1) begin
            abort          = 1'b1;
            wif.word_valid = 1'b1;
            wif.word_data  = WW'($urandom);
            tick();
            abort          = 1'b0;
            wif.word_valid = 1'b0;
            check_status("abort", 1'b0, 1'b0, exp_loaded, 1'b0);
            check("abort_cnt", CW'(word_count), CW'(acc));
            check("abort_cfg", config_out, exp_cfg);
            exp_done = 1'b0;
            exp_cnt  = acc;
        end else begin
            reset          = 1'b1;
            wif.word_valid = 1'b1;
            tick();
            reset          = 1'b0;
            wif.word_valid = 1'b0;
            exp_cfg    = '0;
            exp_loaded = 1'b0;
            exp_done   = 1'b0;
            exp_cnt    = 0;
            check_status("rst", 1'b0, 1'b0, 1'b0, 1'b0);
            check("rst_cfg", config_out, exp_cfg);
            check("rst_cnt", CW'(word_count), CW'(0));
        end
    endtask

    // Idle/done dwell with stray valid beats that must not be taken.
    task automatic dwell(input int n);
        wif.word_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            wif.word_data = WW'($urandom);
            abort = ($urandom_range(0, 1) == 1);
            tick();
            check_status("dwell", 1'b0, exp_done, exp_loaded, 1'b0);
            check("dwell_cnt", CW'(word_count), CW'(exp_cnt));
            check("dwell_cfg", config_out, exp_cfg);
        end
        wif.word_valid = 1'b0;
        abort = 1'b0;
    endtask

    task automatic rand_frame();
        for (int i = 0; i < NW; i++) frame[i] = WW'($urandom);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        wif.word_valid = 1'b0;
        wif.word_data  = '0;
        exp_cfg    = '0;
        exp_loaded = 1'b0;
        exp_done   = 1'b0;
        exp_cnt    = 0;
        tick();
        tick();
        reset = 1'b0;
        check_status("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_cfg", config_out, '0);
        check("reset_cnt", CW'(word_count), CW'(0));
        dwell(3);

        // Basic ascending frame
        for (int i = 0; i < NW; i++) frame[i] = WW'(i);
        run_frame(0, 0, 0, 1'b0);
        check("basic_w1",   CW'(config_out[63:32]),   CW'(1));
        check("basic_last", CW'(config_out[523:512]), CW'(12'h010));
        dwell(2);

        // Same frame with back-pressure gaps
        run_frame(0, 0, 40, 1'b0);

        // Last-word truncation
        for (int i = 0; i < NW; i++) frame[i] = '0;
        frame[NW-1] = 32'hFFFF_FFFF;
        run_frame(0, 0, 20, 1'b0);
        check("trunc_top", CW'(config_out[523:512]), CW'(12'hFFF));
        check("trunc_low", CW'(config_out[511:0]),   CW'(0));

        // Abort mid-load keeps frame A
        rand_frame();
        run_frame(0, 0, 10, 1'b0);
        rand_frame();
        run_frame(1, 5, 30, 1'b0);
        dwell(3);

        // Reset after 8 words
        rand_frame();
        run_frame(2, 8, 25, 1'b0);
        dwell(2);

        // Start pokes during LOAD, then reload from DONE
        rand_frame();
        run_frame(0, 0, 30, 1'b1);
        rand_frame();
        run_frame(0, 0, 20, 1'b1);

        // Random mix
        for (int k = 0; k < 8; k++) begin
            int mode;
            mode = $urandom_range(0, 3);
            rand_frame();
            if (mode == 1)      run_frame(1, $urandom_range(0, NW - 1), 30, 1'b1);
            else if (mode == 2) run_frame(2, $urandom_range(0, NW - 1), 30, 1'b1);
            else                run_frame(0, 0, $urandom_range(0, 60), 1'b1);
            dwell($urandom_range(1, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
